// File: rtl/res_scan_pkg.sv
// res_scan_pkg: shared types and constants for the result-buffer scan sequencer.
//    state_t    : scan FSM states
//    L1/L2/L3   : layer identifiers as driven on out_layer
//    DEF_N*     : default element counts of the conv1/conv2/conv3 result buffers
//    layer_bit  : layer id to one-hot bit (bit0 = conv1)
package res_scan_pkg;

   typedef enum logic [1:0] {IDLE, SEL, WAIT, PRESENT} state_t;

   localparam logic [1:0] L1 = 2'd1;
   localparam logic [1:0] L2 = 2'd2;
   localparam logic [1:0] L3 = 2'd3;

   localparam int DEF_N1 = 2560;
   localparam int DEF_N2 = 1152;
   localparam int DEF_N3 = 1152;

   function automatic logic [2:0] layer_bit(input logic [1:0] l);
      return (l == L1) ? 3'b001 : (l == L2) ? 3'b010 : (l == L3) ? 3'b100 : 3'b000;
   endfunction

endpackage

// File: rtl/res_scan_arb.sv
// res_scan_arb: trigger bookkeeping and fixed-priority layer pick for res_scan_ctrl.
//    clk, rst_n : clock, asynchronous active-low reset
//    trig[2:0]  : rescaled-valid pulses, bit0 = conv1
//    scanning   : one-hot of the layer currently being scanned (0 when idle)
//    take       : the controller starts a scan of 'pick' this cycle
//    pick       : highest-priority pending layer (1 > 2 > 3), 0 when none
//    overrun    : sticky dropped-trigger flags, cleared only by reset
import res_scan_pkg::*;

module res_scan_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] trig,
   input  logic [2:0] scanning,
   input  logic       take,
   output logic [1:0] pick,
   output logic [2:0] overrun
);

   logic [2:0] pend_q, pend_d;
   logic [2:0] ovr_q, ovr_d;

   always_comb begin
      pick = pend_q[0] ? L1 : pend_q[1] ? L2 : pend_q[2] ? L3 : 2'd0;
      // A trigger is only accepted when that layer is neither queued nor in flight;
      // otherwise it is dropped and flagged.
      pend_d = (pend_q & ~(take ? layer_bit(pick) : 3'b000)) | (trig & ~pend_q & ~scanning);
      ovr_d  = ovr_q | (trig & (pend_q | scanning));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         ovr_q  <= '0;
      end else begin
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
      end
   end

   assign overrun = ovr_q;

endmodule

// File: rtl/res_scan_ctrl.sv
// res_scan_ctrl: sweeps the res_test select of a triggered layer over every element
// and streams the returned bytes out over a valid/ready interface.
//    clk, rst_n               : clock, asynchronous active-low reset
//    conv{1,2,3}_valid_o_rescaled : one-cycle "buffer ready" pulses
//    conv{1,2,3}_res_test     : byte returned by res_test for the current select
//    res_sel_{1,2,3}          : select indices; idle value is the layer's element count
//    out_data/out_valid/out_ready : byte stream, out_layer = source layer, out_last = final byte
//    busy                     : scan in progress
//    overrun                  : sticky per-layer dropped-trigger flags
import res_scan_pkg::*;

module res_scan_ctrl #(
   parameter int N1     = DEF_N1,
   parameter int N2     = DEF_N2,
   parameter int N3     = DEF_N3,
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        conv1_valid_o_rescaled,
   input  logic        conv2_valid_o_rescaled,
   input  logic        conv3_valid_o_rescaled,
   input  logic [7:0]  conv1_res_test,
   input  logic [7:0]  conv2_res_test,
   input  logic [7:0]  conv3_res_test,
   output logic [11:0] res_sel_1,
   output logic [10:0] res_sel_2,
   output logic [10:0] res_sel_3,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_layer,
   output logic        out_last,
   output logic        busy,
   output logic [2:0]  overrun
);

   localparam logic [11:0] LAST1 = 12'(N1 - 1);
   localparam logic [11:0] LAST2 = 12'(N2 - 1);
   localparam logic [11:0] LAST3 = 12'(N3 - 1);

   state_t      state_q, state_d;
   logic [1:0]  cur_q, cur_d;
   logic [11:0] idx_q, idx_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic [1:0]  out_layer_q, out_layer_d;
   logic        out_last_q, out_last_d;

   logic [1:0]  pick;
   logic        take;
   logic        cap;
   logic        is_last;
   logic [7:0]  mux_data;
   logic [2:0]  scanning;

   assign busy     = state_q != IDLE;
   assign scanning = busy ? layer_bit(cur_q) : 3'b000;

   res_scan_arb u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .trig     ({conv3_valid_o_rescaled, conv2_valid_o_rescaled, conv1_valid_o_rescaled}),
      .scanning (scanning),
      .take     (take),
      .pick     (pick),
      .overrun  (overrun)
   );

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_layer_d = out_layer_q;
      out_last_d  = out_last_q;
      take        = 1'b0;
      is_last     = idx_q == ((cur_q == L1) ? LAST1 : (cur_q == L2) ? LAST2 : LAST3);
      mux_data    = (cur_q == L1) ? conv1_res_test : (cur_q == L2) ? conv2_res_test : conv3_res_test;
      // The byte is registered on the edge that enters PRESENT, so out_valid is
      // already high in the first PRESENT cycle and a byte costs RD_LAT+2 cycles.
      cap         = (state_q == SEL && RD_LAT == 0) || (state_q == WAIT && cnt_q == 2'd1);
      if (cap) begin
         out_data_d  = mux_data;
         out_valid_d = 1'b1;
         out_layer_d = cur_q;
         out_last_d  = is_last;
      end
      case (state_q)
         IDLE: begin
            if (pick != 2'd0) begin
               take    = 1'b1;
               cur_d   = pick;
               idx_d   = '0;
               state_d = SEL;
            end
         end
         SEL: begin
            cnt_d   = 2'(RD_LAT);
            state_d = (RD_LAT == 0) ? PRESENT : WAIT;
         end
         WAIT: begin
            cnt_d   = cnt_q - 2'd1;
            state_d = (cnt_q == 2'd1) ? PRESENT : WAIT;
         end
         PRESENT: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = is_last ? IDLE : SEL;
               idx_d       = is_last ? idx_q : idx_q + 12'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_layer_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_layer_q <= out_layer_d;
         out_last_q  <= out_last_d;
      end
   end

   // Only the layer being scanned sees idx; all others (and the scanned one once
   // back in IDLE) sit at their element count, so a select never wraps.
   assign res_sel_1 = (busy && cur_q == L1) ? idx_q        : 12'(N1);
   assign res_sel_2 = (busy && cur_q == L2) ? idx_q[10:0]  : 11'(N2);
   assign res_sel_3 = (busy && cur_q == L3) ? idx_q[10:0]  : 11'(N3);

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_layer = out_layer_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_res_scan_ctrl.sv
// tb_res_scan_ctrl: directed bench for res_scan_ctrl with a scan-level reference model.
module tb_res_scan_ctrl;

   localparam int N1 = 2560;
   localparam int N2 = 1152;
   localparam int N3 = 1152;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0, ordy = 1'b1;
   logic [7:0] c1, c2, c3;
   logic [11:0] sel1;
   logic [10:0] sel2, sel3;
   logic [7:0] od;
   logic ov, olast, busy;
   logic [1:0] ol;
   logic [2:0] ovr;

   res_scan_ctrl #(.N1(N1), .N2(N2), .N3(N3), .RD_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .conv1_valid_o_rescaled(p1), .conv2_valid_o_rescaled(p2), .conv3_valid_o_rescaled(p3),
      .conv1_res_test(c1), .conv2_res_test(c2), .conv3_res_test(c3),
      .res_sel_1(sel1), .res_sel_2(sel2), .res_sel_3(sel3),
      .out_data(od), .out_valid(ov), .out_ready(ordy), .out_layer(ol), .out_last(olast),
      .busy(busy), .overrun(ovr));

   // latency-sweep instances, conv3 only
   logic lp = 1'b0;
   logic [7:0] d0, d3;
   logic [11:0] s1_0, s1_3;
   logic [10:0] s2_0, s2_3, s3_0, s3_3;
   logic [7:0] od0, od3;
   logic ov0, ov3, olast0, olast3, busy0, busy3;
   logic [1:0] ol0, ol3;
   logic [2:0] ovr0, ovr3;
   logic [10:0] r1, r2, r3;

   res_scan_ctrl #(.N1(N1), .N2(N2), .N3(N3), .RD_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .conv1_valid_o_rescaled(1'b0), .conv2_valid_o_rescaled(1'b0), .conv3_valid_o_rescaled(lp),
      .conv1_res_test(8'h00), .conv2_res_test(8'h00), .conv3_res_test(d0),
      .res_sel_1(s1_0), .res_sel_2(s2_0), .res_sel_3(s3_0),
      .out_data(od0), .out_valid(ov0), .out_ready(1'b1), .out_layer(ol0), .out_last(olast0),
      .busy(busy0), .overrun(ovr0));

   res_scan_ctrl #(.N1(N1), .N2(N2), .N3(N3), .RD_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .conv1_valid_o_rescaled(1'b0), .conv2_valid_o_rescaled(1'b0), .conv3_valid_o_rescaled(lp),
      .conv1_res_test(8'h00), .conv2_res_test(8'h00), .conv3_res_test(d3),
      .res_sel_1(s1_3), .res_sel_2(s2_3), .res_sel_3(s3_3),
      .out_data(od3), .out_valid(ov3), .out_ready(1'b1), .out_layer(ol3), .out_last(olast3),
      .busy(busy3), .overrun(ovr3));

   // bench copy of res_test: byte pattern per layer, RD_LAT cycles after the select
   function automatic logic [7:0] fdat(input int k, input int i);
      logic [7:0] b;
      b = 8'(i);
      return (k == 1) ? (b ^ 8'hA5) : (k == 2) ? (b ^ 8'h3C) : b;
   endfunction

   always @(posedge clk) begin
      c1 <= fdat(1, int'(sel1));
      c2 <= fdat(2, int'(sel2));
      c3 <= fdat(3, int'(sel3));
      r1 <= s3_3;
      r2 <= r1;
      r3 <= r2;
   end
   assign d0 = s3_0[7:0];
   assign d3 = r3[7:0];

   int nvec = 0, nerr = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      nvec++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   function automatic int nof(input int k);
      return (k == 1) ? N1 : (k == 2) ? N2 : N3;
   endfunction

   // scan-level model: queued layers, the layer in flight and its next byte index
   int m_active = 0, m_idx = 0;
   bit [2:0] m_pend = 0, m_ovr = 0;
   bit hold = 0, h_last = 0;
   logic [7:0] h_data;
   logic [1:0] h_layer;
   int hs_n[4];
   int hs_first = -1, hs_last = -1, last_n = 0, l2_first = -1;
   logic [7:0] last_byte, first_byte;

   always @(negedge clk) begin
      logic [2:0] trig;
      if (!rst_n) begin
         m_active = 0; m_pend = 0; m_ovr = 0; m_idx = 0; hold = 0;
      end else begin
         chk("overrun", 32'(ovr), 32'(m_ovr));
         if (hold) begin
            chk("stall_valid", 32'(ov), 1);
            chk("stall_data", 32'(od), 32'(h_data));
            chk("stall_layer", 32'(ol), 32'(h_layer));
            chk("stall_last", 32'(olast), 32'(h_last));
         end
         if (m_active != 1) chk("sel1_idle", 32'(sel1), N1);
         if (m_active != 2) chk("sel2_idle", 32'(sel2), N2);
         if (m_active != 3) chk("sel3_idle", 32'(sel3), N3);
         if (m_active == 0) begin
            chk("idle_valid", 32'(ov), 0);
            if (m_pend == 0) chk("idle_busy", 32'(busy), 0);
         end
         trig = {p3, p2, p1};
         for (int k = 1; k <= 3; k++)
            if (trig[k-1]) begin
               if (m_pend[k-1] || m_active == k) m_ovr[k-1] = 1'b1;
               else m_pend[k-1] = 1'b1;
            end
         if (ov && ordy) begin
            if (m_active == 0) chk("unexpected_byte", 32'(ov), 0);
            else begin
               chk("byte_data", 32'(od), 32'(fdat(m_active, m_idx)));
               chk("byte_layer", 32'(ol), m_active);
               chk("byte_last", 32'(olast), 32'(m_idx == nof(m_active) - 1));
               if (hs_first < 0) begin hs_first = cyc; first_byte = od; end
               hs_last = cyc;
               if (m_active == 2 && l2_first < 0) l2_first = hs_n[1];
               hs_n[m_active]++;
               if (olast) begin last_n++; last_byte = od; end
               m_idx++;
               if (m_idx == nof(m_active)) m_active = 0;
            end
         end
         hold = ov && !ordy;
         h_data = od; h_layer = ol; h_last = olast;
         if (m_active == 0 && m_pend != 0) begin
            m_active = m_pend[0] ? 1 : m_pend[1] ? 2 : 3;
            m_pend[m_active-1] = 1'b0;
            m_idx = 0;
         end
      end
   end

   // latency-sweep instances: every valid byte is accepted, check it in order
   int i0 = 0, i3 = 0;
   always @(negedge clk) begin
      if (rst_n && ov0) begin
         chk("lat0_data", 32'(od0), 32'(i0[7:0]));
         chk("lat0_last", 32'(olast0), 32'(i0 == N3 - 1));
         i0++;
      end
      if (rst_n && ov3) begin
         chk("lat3_data", 32'(od3), 32'(i3[7:0]));
         chk("lat3_last", 32'(olast3), 32'(i3 == N3 - 1));
         i3++;
      end
   end

   bit rnd_rdy = 0;
   initial forever begin
      @(posedge clk); #1;
      if (rnd_rdy) ordy = ($urandom_range(0, 3) != 0);
   end

   task automatic pulse(input logic [2:0] m);
      @(posedge clk); #1 {p3, p2, p1} = m;
      @(posedge clk); #1 {p3, p2, p1} = 3'b000;
   endtask

   task automatic clr_stats();
      for (int k = 0; k < 4; k++) hs_n[k] = 0;
      hs_first = -1; hs_last = -1; last_n = 0; l2_first = -1;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int n = 0;
      while (!(m_active == 0 && m_pend == 0 && busy == 1'b0) && n < budget) begin
         @(negedge clk); n++;
      end
      chk(nm, 32'(n < budget), 1);
   endtask

   task automatic wait_hs(input string nm, input int k, input int cnt, input int budget);
      int n = 0;
      while (hs_n[k] < cnt && n < budget) begin
         @(negedge clk); n++;
      end
      chk(nm, 32'(n < budget), 1);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_sel1"}, 32'(sel1), N1);
      chk({nm, "_sel2"}, 32'(sel2), N2);
      chk({nm, "_sel3"}, 32'(sel3), N3);
      chk({nm, "_data"}, 32'(od), 0);
      chk({nm, "_valid"}, 32'(ov), 0);
      chk({nm, "_layer"}, 32'(ol), 0);
      chk({nm, "_last"}, 32'(olast), 0);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_overrun"}, 32'(ovr), 0);
   endtask

   initial begin
      #1500000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int f0, f3, n;
      #1 chk_reset_vals("reset");
      #11 rst_n = 1'b1;

      // latency sweep: first valid at cycle RD_LAT+3, pulse cycle being cycle 0
      @(posedge clk); #1 lp = 1'b1;
      f0 = -1; f3 = -1;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (f0 < 0 && ov0) f0 = n;
         if (f3 < 0 && ov3) f3 = n;
         @(posedge clk); #1 lp = 1'b0;
      end
      chk("lat0_first_valid", 32'(f0), 3);
      chk("lat3_first_valid", 32'(f3), 6);
      n = 0;
      while ((i0 < N3 || i3 < N3 || busy0 || busy3) && n < 10000) begin @(negedge clk); n++; end
      chk("lat_bytes0", 32'(i0), N3);
      chk("lat_bytes3", 32'(i3), N3);
      chk("lat_sel3_idle0", 32'(s3_0), N3);
      chk("lat_sel3_idle3", 32'(s3_3), N3);

      // conv3 full scan, ready held high
      clr_stats();
      pulse(3'b100);
      wait_done("scan3_done", 8000);
      chk("scan3_count", 32'(hs_n[3]), 1152);
      chk("scan3_last_count", 32'(last_n), 1);
      chk("scan3_last_byte", 32'(last_byte), 32'h7F);
      chk("scan3_span", 32'(hs_last - hs_first), 3453);   // 1151 intervals of 3 cycles
      chk("scan3_sel_after", 32'(sel3), 1152);
      chk("scan3_busy_after", 32'(busy), 0);

      // conv1 + conv2 together, random backpressure
      clr_stats();
      rnd_rdy = 1;
      pulse(3'b011);
      wait_done("prio_done", 40000);
      rnd_rdy = 0;
      @(posedge clk); #1 ordy = 1'b1;
      chk("prio_l1_count", 32'(hs_n[1]), 2560);
      chk("prio_l2_count", 32'(hs_n[2]), 1152);
      chk("prio_l1_before_l2", 32'(l2_first), 2560);
      chk("prio_first_byte", 32'(first_byte), 32'hA5);

      // overrun on conv2, then conv2 queued behind a conv1 scan
      clr_stats();
      pulse(3'b010);
      wait_hs("ovr_wait50", 2, 50, 1000);
      pulse(3'b010);
      wait_done("ovr_done", 8000);
      chk("ovr_flags", 32'(ovr), 32'b010);
      chk("ovr_l2_count", 32'(hs_n[2]), 1152);
      clr_stats();
      pulse(3'b001);
      wait_hs("queue_wait100", 1, 100, 1000);
      pulse(3'b010);
      wait_done("queue_done", 20000);
      chk("queue_l1_count", 32'(hs_n[1]), 2560);
      chk("queue_l2_count", 32'(hs_n[2]), 1152);
      chk("queue_l2_after_l1", 32'(l2_first), 2560);
      chk("queue_ovr_flags", 32'(ovr), 32'b010);

      // reset in the middle of a conv1 scan
      clr_stats();
      pulse(3'b001);
      wait_hs("rst_wait500", 1, 500, 3000);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midreset");
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b1;
      clr_stats();
      repeat (40) @(negedge clk);
      chk("post_reset_bytes", 32'(hs_n[1] + hs_n[2] + hs_n[3]), 0);
      chk("post_reset_busy", 32'(busy), 0);
      chk("post_reset_valid", 32'(ov), 0);

      // a fresh trigger is served normally after the reset
      pulse(3'b100);
      wait_done("post_reset_scan", 8000);
      chk("post_reset_l3_count", 32'(hs_n[3]), 1152);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
